// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS definitions: sync header codes, block-sync FSM states and
// the scrambler polynomial taps (x^58 + x^39 + 1).
package pcs_pkg;

    localparam int BLOCK_W = 64;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam int SCR_TAP_HI = 58;
    localparam int SCR_TAP_LO = 39;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SLIP     = 2'd1,
        LOCKED   = 2'd2
    } sync_state_e;

    // Only the two transition patterns are legal sync headers; 00 and 11 are not.
    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/pcs_rx_block_sync_if.sv
// Block-level bus between the RX gearbox, the block synchroniser and the
// downstream decoder. The gearbox side is the master, the synchroniser the slave.
interface pcs_rx_block_sync_if;
    import pcs_pkg::*;

    logic               rx_valid;
    logic [1:0]         rx_header;
    logic [BLOCK_W-1:0] rx_block;
    logic               rx_slip;
    logic               block_lock;
    logic               out_valid;
    logic [1:0]         out_header;
    logic [BLOCK_W-1:0] out_data;

    modport master (
        output rx_valid, rx_header, rx_block,
        input  rx_slip, block_lock, out_valid, out_header, out_data
    );

    modport slave (
        input  rx_valid, rx_header, rx_block,
        output rx_slip, block_lock, out_valid, out_header, out_data
    );

endinterface

// File: rtl/pcs_descramble64.sv
// Self-synchronising 64-bit parallel descrambler for x^58 + x^39 + 1.
// The slice is combinational; only the 58-bit history of received scrambled
// bits is registered, and it advances only when en is high.
module pcs_descramble64
    import pcs_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [BLOCK_W-1:0] din,
    output logic [BLOCK_W-1:0] dout
);

    logic [SCR_TAP_HI-1:0]         hist_q;
    logic [SCR_TAP_HI-1:0]         hist_d;
    logic [BLOCK_W+SCR_TAP_HI-1:0] x;

    // Bit stream view: oldest history bit at index 0, newest received bit on top.
    assign x = {din, hist_q};

    // Each output bit cancels the two feedback taps 39 and 58 bits back in the stream.
    always_comb begin
        dout   = '0;
        hist_d = hist_q;
        for (int i = 0; i < BLOCK_W; i++) begin
            dout[i] = x[i+SCR_TAP_HI] ^ x[i+SCR_TAP_HI-SCR_TAP_LO] ^ x[i];
        end
        if (en) begin
            hist_d = din[BLOCK_W-1 -: SCR_TAP_HI];
        end
    end

    // History register: the last 58 scrambled bits seen on the wire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/pcs_rx_block_sync.sv
// 64b/66b receive block synchroniser: sync-header lock FSM with gearbox bitslip
// request, plus payload descrambling and a one-cycle registered output stage.
module pcs_rx_block_sync
    import pcs_pkg::*;
#(
    parameter int LOCK_CNT  = 64,
    parameter int WINDOW    = 64,
    parameter int BAD_MAX   = 16,
    parameter int SLIP_WAIT = 32
) (
    input  logic                clk,
    input  logic                reset,
    pcs_rx_block_sync_if.slave  bus
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WINDOW + 1);
    localparam int BAD_W  = $clog2(BAD_MAX + 1);
    localparam int SLIP_W = $clog2(SLIP_WAIT + 1);

    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_MAX - 1);
    localparam logic [SLIP_W-1:0] SLIP_LOAD = SLIP_W'(SLIP_WAIT);
    localparam logic [SLIP_W-1:0] SLIP_ONE  = SLIP_W'(1);

    sync_state_e        state_q, state_d;
    logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d;
    logic [SLIP_W-1:0]  slip_cnt_q, slip_cnt_d;
    logic               block_lock_q, block_lock_d;
    logic               rx_slip_q, rx_slip_d;
    logic               out_valid_q, out_valid_d;
    logic [1:0]         out_header_q, out_header_d;
    logic [BLOCK_W-1:0] out_data_q, out_data_d;

    logic               sh_ok;
    logic [BLOCK_W-1:0] descr_data;

    assign sh_ok = sh_is_valid(bus.rx_header);

    pcs_descramble64 u_descramble (
        .clk   (clk),
        .reset (reset),
        .en    (bus.rx_valid),
        .din   (bus.rx_block),
        .dout  (descr_data)
    );

    // Lock FSM next state and output stage; nothing advances without rx_valid,
    // while the slip and valid strobes fall back to 0 on idle cycles.
    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        win_cnt_d    = win_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        slip_cnt_d   = slip_cnt_q;
        block_lock_d = block_lock_q;
        rx_slip_d    = 1'b0;
        out_valid_d  = 1'b0;
        out_header_d = out_header_q;
        out_data_d   = out_data_q;

        if (bus.rx_valid) begin
            // Output qualification uses the lock state held before this block.
            out_valid_d  = block_lock_q;
            out_header_d = bus.rx_header;
            out_data_d   = descr_data;

            case (state_q)
                UNLOCKED: begin
                    if (sh_ok) begin
                        if (good_cnt_q == GOOD_LAST) begin
                            state_d      = LOCKED;
                            block_lock_d = 1'b1;
                            good_cnt_d   = '0;
                            win_cnt_d    = '0;
                            bad_cnt_d    = '0;
                        end else begin
                            good_cnt_d = good_cnt_q + GOOD_W'(1);
                        end
                    end else begin
                        rx_slip_d  = 1'b1;
                        good_cnt_d = '0;
                        slip_cnt_d = SLIP_LOAD;
                        state_d    = SLIP;
                    end
                end

                SLIP: begin
                    // Headers are meaningless while the gearbox settles.
                    if (slip_cnt_q == SLIP_ONE) begin
                        slip_cnt_d = '0;
                        state_d    = UNLOCKED;
                    end else begin
                        slip_cnt_d = slip_cnt_q - SLIP_ONE;
                    end
                end

                LOCKED: begin
                    // Loss of lock takes priority over a coincident window end.
                    if (!sh_ok && (bad_cnt_q == BAD_LAST)) begin
                        block_lock_d = 1'b0;
                        rx_slip_d    = 1'b1;
                        slip_cnt_d   = SLIP_LOAD;
                        win_cnt_d    = '0;
                        bad_cnt_d    = '0;
                        state_d      = SLIP;
                    end else if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        bad_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        if (!sh_ok) begin
                            bad_cnt_d = bad_cnt_q + BAD_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = UNLOCKED;
                end
            endcase
        end
    end

    // Every register returns to its idle value as soon as reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= UNLOCKED;
            good_cnt_q   <= '0;
            win_cnt_q    <= '0;
            bad_cnt_q    <= '0;
            slip_cnt_q   <= '0;
            block_lock_q <= 1'b0;
            rx_slip_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_header_q <= '0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            win_cnt_q    <= win_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            block_lock_q <= block_lock_d;
            rx_slip_q    <= rx_slip_d;
            out_valid_q  <= out_valid_d;
            out_header_q <= out_header_d;
            out_data_q   <= out_data_d;
        end
    end

    assign bus.rx_slip    = rx_slip_q;
    assign bus.block_lock = block_lock_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_header = out_header_q;
    assign bus.out_data   = out_data_q;

endmodule
